// File: rtl/engine_arbiter.sv
// Arbitrates N drawing-engine channels onto one frame-memory port, one request in flight,
// and broadcasts read data back with a one-hot strobe marking the owning channel.
module engine_arbiter #(
    parameter int NUM_CH   = 5,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int ARB_MODE = 0,
    localparam int WBEN_W  = DATA_W / 8,
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [NUM_CH*DATA_W-1:0]   ch_in_data,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_in_addr,
    input  logic [NUM_CH*WBEN_W-1:0]   ch_in_wben,
    input  logic [NUM_CH-1:0]          ch_in_op,
    input  logic [NUM_CH-1:0]          ch_in_rts,
    output logic [NUM_CH-1:0]          ch_out_rtr,
    output logic [DATA_W-1:0]          mem_out_data,
    output logic [ADDR_W-1:0]          mem_out_addr,
    output logic [WBEN_W-1:0]          mem_out_wben,
    output logic                       mem_out_op,
    output logic                       mem_out_rts,
    input  logic                       mem_in_rtr,
    input  logic [DATA_W-1:0]          mem_in_data,
    input  logic                       mem_in_valid,
    output logic [DATA_W-1:0]          bcast_out_data,
    output logic [NUM_CH-1:0]          bcast_out_xfc
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] sel_idx;
    logic             any_req;

    // Round-robin scans from last+1 with wrap; fixed priority scans from index 0.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_CH-1:0] rts,
                                              input logic [IDX_W-1:0]  last);
        logic [IDX_W-1:0]  idx;
        logic              found;
        logic [NUM_CH-1:0] sh;
        int                c;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == 1)
                c = k;
            else
                c = (int'(last) + 1 + k) % NUM_CH;
            sh = rts >> c;
            if (!found && sh[0]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
        return idx;
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

    assign any_req    = |ch_in_rts;
    assign sel_idx    = pick(ch_in_rts, last_grant);
    assign ch_out_rtr = (state == IDLE && any_req) ? onehot(sel_idx) : '0;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state          <= IDLE;
            last_grant     <= IDX_W'(NUM_CH - 1);
            grant          <= '0;
            mem_out_data   <= '0;
            mem_out_addr   <= '0;
            mem_out_wben   <= '0;
            mem_out_op     <= 1'b0;
            mem_out_rts    <= 1'b0;
            bcast_out_data <= '0;
            bcast_out_xfc  <= '0;
        end else begin
            bcast_out_xfc <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_out_data <= ch_in_data[sel_idx*DATA_W +: DATA_W];
                        mem_out_addr <= ch_in_addr[sel_idx*ADDR_W +: ADDR_W];
                        mem_out_wben <= ch_in_wben[sel_idx*WBEN_W +: WBEN_W];
                        mem_out_op   <= ch_in_op[sel_idx];
                        mem_out_rts  <= 1'b1;
                        grant        <= sel_idx;
                        last_grant   <= sel_idx;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Fields stay latched here so memory may stall for any length of time.
                    if (mem_in_rtr) begin
                        mem_out_rts <= 1'b0;
                        state       <= mem_out_op ? RD_WAIT : IDLE;
                    end
                end
                RD_WAIT: begin
                    if (mem_in_valid) begin
                        bcast_out_data <= mem_in_data;
                        bcast_out_xfc  <= onehot(grant);
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_engine_arbiter.sv
// Bench for engine_arbiter: random and directed engine/memory traffic checked against a
// transaction-level scoreboard, plus a fixed-priority instance exercised directly.
module tb_engine_arbiter;

    localparam int NUM_CH = 5;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int WBEN_W = DATA_W / 8;
    localparam int IDX_W  = 3;

    logic                     clk = 1'b0;
    logic                     rst_ = 1'b0;
    logic [NUM_CH*DATA_W-1:0] ch_in_data;
    logic [NUM_CH*ADDR_W-1:0] ch_in_addr;
    logic [NUM_CH*WBEN_W-1:0] ch_in_wben;
    logic [NUM_CH-1:0]        ch_in_op, ch_in_rts, ch_out_rtr;
    logic [DATA_W-1:0]        mem_out_data, mem_in_data, bcast_out_data;
    logic [ADDR_W-1:0]        mem_out_addr;
    logic [WBEN_W-1:0]        mem_out_wben;
    logic                     mem_out_op, mem_out_rts, mem_in_rtr, mem_in_valid;
    logic [NUM_CH-1:0]        bcast_out_xfc;

    logic [NUM_CH*DATA_W-1:0] fp_ch_in_data;
    logic [NUM_CH*ADDR_W-1:0] fp_ch_in_addr;
    logic [NUM_CH*WBEN_W-1:0] fp_ch_in_wben;
    logic [NUM_CH-1:0]        fp_ch_in_op, fp_ch_in_rts, fp_ch_out_rtr;
    logic [DATA_W-1:0]        fp_mem_out_data, fp_mem_in_data, fp_bcast_out_data;
    logic [ADDR_W-1:0]        fp_mem_out_addr;
    logic [WBEN_W-1:0]        fp_mem_out_wben;
    logic                     fp_mem_out_op, fp_mem_out_rts, fp_mem_in_rtr, fp_mem_in_valid;
    logic [NUM_CH-1:0]        fp_bcast_out_xfc;

    always #5 clk = ~clk;

    engine_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ARB_MODE(0)) dut (
        .clk(clk), .rst_(rst_),
        .ch_in_data(ch_in_data), .ch_in_addr(ch_in_addr), .ch_in_wben(ch_in_wben),
        .ch_in_op(ch_in_op), .ch_in_rts(ch_in_rts), .ch_out_rtr(ch_out_rtr),
        .mem_out_data(mem_out_data), .mem_out_addr(mem_out_addr), .mem_out_wben(mem_out_wben),
        .mem_out_op(mem_out_op), .mem_out_rts(mem_out_rts), .mem_in_rtr(mem_in_rtr),
        .mem_in_data(mem_in_data), .mem_in_valid(mem_in_valid),
        .bcast_out_data(bcast_out_data), .bcast_out_xfc(bcast_out_xfc)
    );

    engine_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_(rst_),
        .ch_in_data(fp_ch_in_data), .ch_in_addr(fp_ch_in_addr), .ch_in_wben(fp_ch_in_wben),
        .ch_in_op(fp_ch_in_op), .ch_in_rts(fp_ch_in_rts), .ch_out_rtr(fp_ch_out_rtr),
        .mem_out_data(fp_mem_out_data), .mem_out_addr(fp_mem_out_addr),
        .mem_out_wben(fp_mem_out_wben), .mem_out_op(fp_mem_out_op),
        .mem_out_rts(fp_mem_out_rts), .mem_in_rtr(fp_mem_in_rtr),
        .mem_in_data(fp_mem_in_data), .mem_in_valid(fp_mem_in_valid),
        .bcast_out_data(fp_bcast_out_data), .bcast_out_xfc(fp_bcast_out_xfc)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [WBEN_W-1:0] wben;
        logic              op;
        int                ch;
    } req_t;

    req_t              mq[$];
    bit                busy = 0, rd_pend = 0;
    int                rd_owner = 0;
    int                m_last = NUM_CH - 1;
    logic [NUM_CH-1:0] exp_xfc = '0;
    logic [DATA_W-1:0] exp_bcast = '0;
    int                g_ch[$], g_cyc[$], x_cyc[$];
    logic [NUM_CH-1:0] x_val[$];

    // Round-robin winner: the requester at the smallest forward distance after the last grant.
    function automatic int ref_pick(input logic [NUM_CH-1:0] rts, input int last);
        int best, bestd, d;
        best  = -1;
        bestd = NUM_CH + 1;
        for (int c = 0; c < NUM_CH; c++) begin
            d = (c - last - 1 + 2 * NUM_CH) % NUM_CH;
            if (bit'(rts >> c) && d < bestd) begin
                bestd = d;
                best  = c;
            end
        end
        return best;
    endfunction

    function automatic logic [NUM_CH-1:0] onehot_v(input int c);
        return NUM_CH'(1) << c;
    endfunction

    always @(negedge clk) begin : monitor
        logic [NUM_CH-1:0] exp_rtr;
        int                c;
        req_t              r;
        if (!rst_) begin
            check("rst_mem_rts", 64'(mem_out_rts), 64'(0));
            check("rst_mem_addr", 64'(mem_out_addr), 64'(0));
            check("rst_mem_data", 64'(mem_out_data), 64'(0));
            check("rst_mem_wben_op", 64'({mem_out_wben, mem_out_op}), 64'(0));
            check("rst_xfc", 64'(bcast_out_xfc), 64'(0));
            check("rst_bcast", 64'(bcast_out_data), 64'(0));
            check("rst_rtr", 64'(ch_out_rtr), 64'(0));
            mq.delete();
            busy      = 0;
            rd_pend   = 0;
            m_last    = NUM_CH - 1;
            exp_xfc   = '0;
            exp_bcast = '0;
        end else begin
            c       = ref_pick(ch_in_rts, m_last);
            exp_rtr = (!busy && c >= 0) ? onehot_v(c) : '0;
            check("rtr", 64'(ch_out_rtr), 64'(exp_rtr));
            check("mem_rts", 64'(mem_out_rts), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("mem_addr", 64'(mem_out_addr), 64'(mq[0].addr));
                check("mem_op", 64'(mem_out_op), 64'(mq[0].op));
                if (!mq[0].op) begin
                    check("mem_data", 64'(mem_out_data), 64'(mq[0].data));
                    check("mem_wben", 64'(mem_out_wben), 64'(mq[0].wben));
                end
            end
            check("xfc", 64'(bcast_out_xfc), 64'(exp_xfc));
            check("bcast", 64'(bcast_out_data), 64'(exp_bcast));
            for (int k = 0; k < NUM_CH; k++)
                if (bit'((ch_out_rtr & ch_in_rts) >> k)) begin
                    g_ch.push_back(k);
                    g_cyc.push_back(cyc);
                end
            if (bcast_out_xfc != 0) begin
                x_cyc.push_back(cyc);
                x_val.push_back(bcast_out_xfc);
            end
            exp_xfc = '0;
            if (exp_rtr != 0) begin
                r.addr = ch_in_addr[c*ADDR_W +: ADDR_W];
                r.data = ch_in_data[c*DATA_W +: DATA_W];
                r.wben = ch_in_wben[c*WBEN_W +: WBEN_W];
                r.op   = bit'(ch_in_op >> c);
                r.ch   = c;
                mq.push_back(r);
                m_last = c;
                busy   = 1;
            end else if (mq.size() != 0) begin
                if (mem_in_rtr) begin
                    r = mq.pop_front();
                    if (r.op) begin
                        rd_pend  = 1;
                        rd_owner = r.ch;
                    end else begin
                        busy = 0;
                    end
                end
            end else if (rd_pend && mem_in_valid) begin
                exp_xfc   = onehot_v(rd_owner);
                exp_bcast = mem_in_data;
                rd_pend   = 0;
                busy      = 0;
            end
        end
    end

    // ---------------- engine and memory drivers ----------------
    bit                mem_auto = 1, rnd_rtr = 0, spurious = 0, refill = 0, hold = 0, rd_rand = 1;
    int                rd_cnt = -1, rd_delay = -1;
    logic [DATA_W-1:0] rd_fixed = '0;

    task automatic new_req(input int c, input bit op, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [WBEN_W-1:0] w);
        ch_in_addr[c*ADDR_W +: ADDR_W] = a;
        ch_in_data[c*DATA_W +: DATA_W] = d;
        ch_in_wben[c*WBEN_W +: WBEN_W] = w;
        ch_in_op[IDX_W'(c)]            = op;
        ch_in_rts[IDX_W'(c)]           = 1'b1;
    endtask

    task automatic tick();
        logic [NUM_CH-1:0] g;
        bit                racc;
        @(negedge clk);
        g    = ch_out_rtr & ch_in_rts;
        racc = mem_out_rts & mem_in_rtr & mem_out_op;
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bit'(g >> c) && !hold) ch_in_rts[IDX_W'(c)] = 1'b0;
            if (refill) begin
                if (!bit'(ch_in_rts >> c)) begin
                    if ($urandom_range(0, 3) == 0)
                        new_req(c, bit'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom));
                end else if (!bit'(g >> c) && $urandom_range(0, 19) == 0) begin
                    ch_in_rts[IDX_W'(c)] = 1'b0;
                end
            end
        end
        if (mem_auto) begin
            if (rnd_rtr) mem_in_rtr = ($urandom_range(0, 3) != 0);
            mem_in_valid = 1'b0;
            mem_in_data  = $urandom;
            if (racc) rd_cnt = (rd_delay < 0) ? int'($urandom_range(0, 4)) : rd_delay - 1;
            if (rd_cnt == 0) begin
                mem_in_valid = 1'b1;
                mem_in_data  = rd_rand ? $urandom : rd_fixed;
                rd_cnt       = -1;
            end else if (rd_cnt > 0) begin
                rd_cnt--;
            end else if (spurious && $urandom_range(0, 9) == 0) begin
                mem_in_valid = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || mq.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check(name, 64'(busy || mq.size() != 0), 64'(0));
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        repeat (2) tick();
        rst_ = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, n2, n4, gc0;
        bit found, rtr_seen;
        ch_in_data = '0; ch_in_addr = '0; ch_in_wben = '0; ch_in_op = '0; ch_in_rts = '0;
        mem_in_rtr = 1'b0; mem_in_valid = 1'b0; mem_in_data = '0;
        fp_ch_in_data = '0; fp_ch_in_addr = '0; fp_ch_in_wben = '0; fp_ch_in_op = '0;
        fp_ch_in_rts = '0; fp_mem_in_rtr = 1'b0; fp_mem_in_valid = 1'b0; fp_mem_in_data = '0;
        repeat (3) tick();
        check("rst_fp_rts", 64'(fp_mem_out_rts), 64'(0));
        check("rst_fp_rtr", 64'(fp_ch_out_rtr), 64'(0));
        rst_ = 1'b1;

        // single write on channel 1
        mem_in_rtr = 1'b1;
        new_req(1, 1'b0, 16'h0010, 32'hDEADBEEF, 4'hF);
        repeat (4) tick();
        check("sw_grants", 64'(g_ch.size()), 64'(1));
        check("sw_ch", 64'(g_ch.size() > 0 ? g_ch[0] : -1), 64'(1));
        check("sw_no_xfc", 64'(x_cyc.size()), 64'(0));
        wait_idle("sw_idle");

        // round-robin fairness from reset with all channels holding writes
        do_reset();
        g_ch.delete(); g_cyc.delete();
        hold = 1;
        for (int c = 0; c < NUM_CH; c++) new_req(c, 1'b0, 16'(16'h0100 + c), $urandom, 4'hF);
        repeat (12) tick();
        hold = 0;
        ch_in_rts = '0;
        wait_idle("rr_idle");
        check("rr_grants", 64'(g_ch.size()), 64'(6));
        for (int k = 0; k < 6 && k < g_ch.size(); k++) begin
            check("rr_order", 64'(g_ch[k]), 64'(k % NUM_CH));
            if (k > 0) check("rr_spacing", 64'(g_cyc[k] - g_cyc[k-1]), 64'(2));
        end

        // read on channel 3, channel 0 arrives during the wait
        g_ch.delete(); g_cyc.delete(); x_cyc.delete(); x_val.delete();
        rd_delay = 3; rd_rand = 0; rd_fixed = 32'hCAFEF00D;
        new_req(3, 1'b1, 16'h1234, '0, '0);
        repeat (3) tick();
        new_req(0, 1'b0, 16'h0040, 32'h0BADF00D, 4'h3);
        n = 0;
        while (x_cyc.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("rd_xfc_count", 64'(x_cyc.size()), 64'(1));
        check("rd_xfc_owner", 64'(x_val.size() > 0 ? x_val[0] : '0), 64'(5'b01000));
        check("rd_bcast", 64'(bcast_out_data), 64'(32'hCAFEF00D));
        gc0 = -1;
        foreach (g_ch[k]) if (g_ch[k] == 0 && gc0 < 0) gc0 = g_cyc[k];
        check("rd_ch0_at_xfc", 64'(gc0), 64'(x_cyc.size() > 0 ? x_cyc[0] : -2));
        wait_idle("rd_idle");

        // memory stall during ISSUE with other channels requesting
        mem_in_rtr = 1'b0;
        new_req(2, 1'b0, 16'h0222, 32'h22222222, 4'h5);
        tick();
        new_req(0, 1'b0, 16'h0000, 32'h00000000, 4'h1);
        new_req(4, 1'b0, 16'h0444, 32'h44444444, 4'h2);
        rtr_seen = 0;
        repeat (10) begin
            tick();
            if (ch_out_rtr != 0) rtr_seen = 1;
        end
        check("stall_rtr_zero", 64'(rtr_seen), 64'(0));
        check("stall_rts_held", 64'(mem_out_rts), 64'(1));
        check("stall_addr", 64'(mem_out_addr), 64'(16'h0222));
        check("stall_data", 64'(mem_out_data), 64'(32'h22222222));
        mem_in_rtr = 1'b1;
        tick();
        check("stall_accept", 64'(mem_out_rts), 64'(0));
        ch_in_rts = '0;
        wait_idle("stall_idle");

        // randomized traffic with random memory back-pressure and stray read strobes
        refill = 1; rnd_rtr = 1; spurious = 1; rd_rand = 1; rd_delay = -1;
        g_ch.delete(); g_cyc.delete();
        repeat (600) tick();
        refill = 0; rnd_rtr = 0; spurious = 0;
        mem_in_rtr = 1'b1;
        ch_in_rts = '0;
        wait_idle("rand_idle");
        check("rand_activity", 64'(g_ch.size() > 50), 64'(1));

        // reset while a read is outstanding, then a late read strobe
        x_cyc.delete();
        rd_delay = 20;
        new_req(3, 1'b1, 16'h0333, '0, '0);
        n = 0;
        while (!rd_pend && n < 20) begin
            tick();
            n++;
        end
        check("rmr_in_rd_wait", 64'(rd_pend), 64'(1));
        tick();
        mem_auto = 0; rd_cnt = -1; ch_in_rts = '0; mem_in_valid = 1'b0;
        rst_ = 1'b0;
        repeat (2) tick();
        rst_ = 1'b1;
        mem_in_valid = 1'b1;
        mem_in_data  = 32'h12345678;
        tick();
        mem_in_valid = 1'b0;
        repeat (3) tick();
        check("rmr_no_xfc", 64'(x_cyc.size()), 64'(0));
        check("rmr_bcast", 64'(bcast_out_data), 64'(0));
        check("rmr_rts", 64'(mem_out_rts), 64'(0));

        // fixed priority instance: channel 2 always beats channel 4
        fp_mem_in_rtr = 1'b1;
        fp_ch_in_addr[2*ADDR_W +: ADDR_W] = 16'h0002;
        fp_ch_in_addr[4*ADDR_W +: ADDR_W] = 16'h0004;
        fp_ch_in_rts = 5'b10100;
        n2 = 0; n4 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (fp_ch_out_rtr == 5'b00100) n2++;
            else if (fp_ch_out_rtr != 0) n4++;
            @(posedge clk);
            #1;
        end
        check("fp_ch2_grants", 64'(n2), 64'(6));
        check("fp_ch4_starved", 64'(n4), 64'(0));
        fp_ch_in_rts = 5'b10000;
        found = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (fp_ch_out_rtr == 5'b10000) found = 1;
            @(posedge clk);
            #1;
        end
        check("fp_ch4_after_drop", 64'(found), 64'(1));
        fp_ch_in_rts = '0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/engine_arbiter.md
# engine_arbiter

Parametrised N-channel arbiter between the drawing engines (fill-rect and successors) and the single frame-memory port. Each engine presents a write or read request with an rts/rtr handshake. The block grants one channel at a time (round-robin or fixed priority) and forwards the latched request to memory. Read data is broadcast to all engines, with a one-hot per-channel strobe marking the owner.

## Interface
- NUM_CH, 5, number of engine channels (1..16)
- DATA_W, 32, data width; multiple of 8
- ADDR_W, 16, memory address width
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- Derived: WBEN_W = DATA_W/8; IDX_W = max(1, clog2(NUM_CH))

Ports:
- clk  in  1  sole clock, rising edge
- rst_  in  1  asynchronous active-low reset
- ch_in_data  in  NUM_CH*DATA_W  write data; channel i in [i*DATA_W +: DATA_W]
- ch_in_addr  in  NUM_CH*ADDR_W  address, same packing
- ch_in_wben  in  NUM_CH*WBEN_W  byte write enables, same packing
- ch_in_op  in  NUM_CH  per channel: 0 = write, 1 = read
- ch_in_rts  in  NUM_CH  per-channel request valid
- ch_out_rtr  out  NUM_CH  one-hot accept
- mem_out_data  out  DATA_W  latched write data
- mem_out_addr  out  ADDR_W  latched address
- mem_out_wben  out  WBEN_W  latched byte enables
- mem_out_op  out  1  latched op
- mem_out_rts  out  1  request valid to memory
- mem_in_rtr  in  1  memory accepts request
- mem_in_data  in  DATA_W  read return data
- mem_in_valid  in  1  read return strobe
- bcast_out_data  out  DATA_W  last read data, broadcast to all channels
- bcast_out_xfc  out  NUM_CH  one-hot, one-cycle strobe to the read's owner

## Operation
- Three-state FSM:
  - IDLE: accepts a new channel request.
  - ISSUE: presents the latched request to memory.
  - RD_WAIT: waits for read data.
- Only one request is in flight. A read blocks new grants until its data returns.
- IDLE:
  - ch_out_rtr is the one-hot of the selected channel, driven combinationally from ch_in_rts. It is zero if no channel has rts set.
  - On an engine transfer (rts & rtr): latch data/addr/wben/op and the grant index into registers, then go to ISSUE.
- Selection:
  - ARB_MODE=0: search starts at last_grant+1 and wraps modulo NUM_CH. last_grant updates on every engine transfer.
  - ARB_MODE=1: lowest asserted index wins; last_grant is unused.
- ISSUE:
  - mem_out_rts=1 and all ch_out_rtr=0.
  - On mem_in_rtr: a write goes to IDLE; a read goes to RD_WAIT.
- RD_WAIT:
  - On mem_in_valid: load bcast_out_data <= mem_in_data, pulse bcast_out_xfc <= onehot(grant) for exactly one cycle, then go to IDLE.
- mem_in_valid outside RD_WAIT is ignored; no xfc pulse and no data update.
- bcast_out_data holds its value until the next read completes.
- Dropping ch_in_rts on a non-granted channel is legal. A granted channel is only granted for the single transfer cycle.
- NUM_CH=1: the channel is always selected when it requests.
- Reset asserted mid-operation forces IDLE immediately. Any outstanding read is abandoned and its later mem_in_valid is ignored.

## Timing
- Reset values:
  - state = IDLE, last_grant = NUM_CH-1 (so channel 0 wins first).
  - mem_out_* = 0, mem_out_rts = 0.
  - bcast_out_data = 0, bcast_out_xfc = 0.
  - ch_out_rtr = 0 until a request appears after reset.
- Engine transfer at edge T0 → mem_out_rts=1 from T0+1.
- Memory accept (mem_out_rts & mem_in_rtr) at edge T1 → mem_out_rts=0 after T1. Next ch_out_rtr can assert in the cycle after T1 for a write.
- Write throughput: one request per 2 cycles with mem_in_rtr held high.
- Read: mem_in_valid sampled at edge T2 → bcast_out_xfc high for the cycle after T2. The next grant is possible in that same cycle (FSM is in IDLE).
- mem_out_* fields are stable while mem_out_rts=1. Memory may stall indefinitely without loss.

## Test plan
- Single write, round-robin:
  - Stimulus: ch1 rts with addr=0x0010, data=0xDEADBEEF, wben=0xF, op=0; mem_in_rtr=1.
  - Required: ch_out_rtr=0b00010 for one cycle; next cycle mem_out_rts=1 carrying the same fields; no bcast_out_xfc.
- Round-robin fairness: ch0..ch4 all hold rts with writes and mem_in_rtr=1 → grant order 0,1,2,3,4,0 with one grant every 2 cycles.
- Fixed priority: ARB_MODE=1 with ch2 and ch4 continuously requesting → ch2 granted every time and ch4 starves; ch4 is granted once ch2 drops rts.
- Read path:
  - Stimulus: ch3 read at addr 0x1234; memory returns 0xCAFEF00D with mem_in_valid 3 cycles after accept; ch0 requests during RD_WAIT.
  - Required: bcast_out_data=0xCAFEF00D and bcast_out_xfc=0b01000 for one cycle; ch0 not granted until the xfc cycle.
- Memory stall: mem_in_rtr=0 for 10 cycles during ISSUE → mem_out_* fields stable and all ch_out_rtr=0 throughout; request transfers on the first mem_in_rtr=1.
- Reset mid-read:
  - Stimulus: assert rst_ low while in RD_WAIT, release, then pulse mem_in_valid.
  - Required: all outputs return to reset values; no xfc pulse; bcast_out_data stays 0.
